// File: rtl/adc128s022_responder.sv
// ADC128S022 serial slave emulator: oversamples the controller's sck/cs_n/din and returns 12-bit channel samples.
// Optional build macro ADC_EMU_DITHER_EN adds LFSR dither on the two LSBs of each loaded sample.
module adc128s022_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_ADDR  = 3'd0
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        adc_sck,
  input  logic        adc_cs_n,
  input  logic        din,
  input  logic [95:0] ch_data,
  output logic        dout,
  output logic        frame_done,
  output logic [2:0]  last_addr
);

  typedef enum logic {IDLE, FRAME} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, din_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, din_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_t      state, state_c;
  logic [15:0] shift, shift_c;
  logic [3:0]  rise_cnt, rise_cnt_c, fall_cnt, fall_cnt_c;
  logic [2:0]  addr, addr_c, addr_next, addr_next_c, last_addr_c;
  logic        dout_c, frame_done_c;
  logic        do_load;
  logic [2:0]  load_addr;
  logic [11:0] sample;
  logic [11:0] ch [8];
`ifdef ADC_EMU_DITHER_EN
  logic [15:0] lfsr, lfsr_c;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    assign ch[gi] = ch_data[12*gi +: 12];
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      din_sync <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      din_sync <= {din_sync[SYNC_STAGES-2:0], din};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      addr       <= RESET_ADDR;
      addr_next  <= RESET_ADDR;
      last_addr  <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
`ifdef ADC_EMU_DITHER_EN
      lfsr       <= 16'hACE1;
`endif
    end else begin
      state      <= state_c;
      shift      <= shift_c;
      rise_cnt   <= rise_cnt_c;
      fall_cnt   <= fall_cnt_c;
      addr       <= addr_c;
      addr_next  <= addr_next_c;
      last_addr  <= last_addr_c;
      dout       <= dout_c;
      frame_done <= frame_done_c;
`ifdef ADC_EMU_DITHER_EN
      lfsr       <= lfsr_c;
`endif
    end
  end

  always_comb begin
    state_c      = state;
    shift_c      = shift;
    rise_cnt_c   = rise_cnt;
    fall_cnt_c   = fall_cnt;
    addr_c       = addr;
    addr_next_c  = addr_next;
    last_addr_c  = last_addr;
    dout_c       = dout;
    frame_done_c = 1'b0;
    do_load      = 1'b0;
    load_addr    = addr;
    sample       = '0;
`ifdef ADC_EMU_DITHER_EN
    lfsr_c       = lfsr;
`endif

    case (state)
      IDLE: begin
        dout_c     = 1'b0;
        rise_cnt_c = '0;
        fall_cnt_c = '0;
        if (cs_fall) begin
          state_c = FRAME;
          do_load = 1'b1;
        end
      end
      FRAME: begin
        if (cs_rise) begin
          // Abort: partial address is dropped, addr keeps its old value
          state_c    = IDLE;
          dout_c     = 1'b0;
          rise_cnt_c = '0;
          fall_cnt_c = '0;
        end else if (sck_rise) begin
          if (rise_cnt inside {4'd2, 4'd3, 4'd4})
            addr_next_c = {addr_next[1:0], din_s};
          rise_cnt_c = rise_cnt + 4'd1;
        end else if (sck_fall) begin
          fall_cnt_c = fall_cnt + 4'd1;
          if (fall_cnt == 4'd15) begin
            addr_c       = addr_next;
            last_addr_c  = addr_next;
            frame_done_c = 1'b1;
            do_load      = 1'b1;
            load_addr    = addr_next;
            dout_c       = 1'b0;
          end else begin
            dout_c = shift[4'd14 - fall_cnt];
          end
        end
      end
      default: state_c = IDLE;
    endcase

    if (do_load) begin
      sample = ch[load_addr];
`ifdef ADC_EMU_DITHER_EN
      sample[1:0] = sample[1:0] ^ lfsr[1:0];
      lfsr_c      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
      shift_c = {4'b0000, sample};
    end
  end

endmodule
